// File: rtl/overlay_motion_if.sv
// overlay_motion_if: control inputs and registered overlay position/status outputs of the motion sequencer
interface overlay_motion_if;
   logic       frame_start;
   logic       run;
   logic       step;
   logic [6:0] origin_x;
   logic [5:0] origin_y;
   logic [2:0] color_idx;
   logic       overlay_en;
   logic       bounce_x;
   logic       bounce_y;
   modport master (
      output frame_start, run, step,
      input  origin_x, origin_y, color_idx, overlay_en, bounce_x, bounce_y
   );
   modport slave (
      input  frame_start, run, step,
      output origin_x, origin_y, color_idx, overlay_en, bounce_x, bounce_y
   );
endinterface

// File: rtl/overlay_motion_ctrl.sv
// overlay_motion_ctrl: frame-synchronous bouncing-banner sequencer for the text overlay origin
module overlay_motion_ctrl #(
   parameter int TEXT_W_CELLS    = 61,
   parameter int TEXT_H_CELLS    = 10,
   parameter int SCREEN_W_CELLS  = 80,
   parameter int SCREEN_H_CELLS  = 60,
   parameter int INIT_X          = 11,
   parameter int INIT_Y          = 38,
   parameter int FRAMES_PER_STEP = 1,
   parameter int BLINK_FRAMES    = 30
) (
   input logic clk,
   input logic rst,
   overlay_motion_if.slave bus
);
   localparam logic [6:0] MAX_X = 7'(SCREEN_W_CELLS - TEXT_W_CELLS);
   localparam logic [5:0] MAX_Y = 6'(SCREEN_H_CELLS - TEXT_H_CELLS);
   localparam int DIV_W = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int BLK_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {HOLD, RUN, BLINK} state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] div;
   logic [BLK_W-1:0] blink_cnt;
   logic             step_pending;
   logic             dir_x, dir_y;
   logic             move, corner, blink_last;
   logic             bx, by, ndx, ndy;
   logic [6:0]       nx;
   logic [5:0]       ny;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= HOLD;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         HOLD:    state_nx = move && corner ? BLINK : bus.run ? RUN : HOLD;
         RUN:     state_nx = !bus.run ? HOLD : move && corner ? BLINK : RUN;
         BLINK:   state_nx = bus.frame_start && blink_last ? (bus.run ? RUN : HOLD) : BLINK;
         default: state_nx = HOLD;
      endcase
   end

   // A bounce reverses direction and steps one cell the new way; a zero range freezes the axis
   always_comb begin
      blink_last = blink_cnt == BLK_LAST;
      move   = bus.frame_start && (state == HOLD ? (step_pending || bus.step)
                                                 : state == RUN && bus.run && div == DIV_LAST);
      bx     = MAX_X != 7'd0 && (dir_x ? bus.origin_x == MAX_X : bus.origin_x == 7'd0);
      by     = MAX_Y != 6'd0 && (dir_y ? bus.origin_y == MAX_Y : bus.origin_y == 6'd0);
      ndx    = bx ? ~dir_x : dir_x;
      ndy    = by ? ~dir_y : dir_y;
      nx     = MAX_X == 7'd0 ? bus.origin_x : ndx ? bus.origin_x + 7'd1 : bus.origin_x - 7'd1;
      ny     = MAX_Y == 6'd0 ? bus.origin_y : ndy ? bus.origin_y + 6'd1 : bus.origin_y - 6'd1;
      corner = bx && by;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.origin_x   <= 7'(INIT_X);
         bus.origin_y   <= 6'(INIT_Y);
         dir_x          <= 1'b1;
         dir_y          <= 1'b1;
         bus.color_idx  <= 3'd0;
         bus.overlay_en <= 1'b1;
         bus.bounce_x   <= 1'b0;
         bus.bounce_y   <= 1'b0;
         div            <= '0;
         blink_cnt      <= '0;
         step_pending   <= 1'b0;
      end else begin
         bus.bounce_x <= move && bx;
         bus.bounce_y <= move && by;
         if (move) begin
            bus.origin_x <= nx;
            bus.origin_y <= ny;
            dir_x        <= ndx;
            dir_y        <= ndy;
            if (bx || by) bus.color_idx <= bus.color_idx + 3'd1;
         end
         step_pending <= state != HOLD ? 1'b0
                       : bus.frame_start && (step_pending || bus.step) ? 1'b0
                       : step_pending || bus.step;
         if (state == RUN)
            div <= !bus.run ? '0 : bus.frame_start ? (div == DIV_LAST ? '0 : div + 1'b1) : div;
         else if (state == BLINK && bus.frame_start && blink_last)
            div <= '0;
         blink_cnt <= state != BLINK ? '0 : bus.frame_start ? blink_cnt + 1'b1 : blink_cnt;
         if (state == BLINK && bus.frame_start)
            bus.overlay_en <= blink_last ? 1'b1 : ~bus.overlay_en;
      end
endmodule
